// File: rtl/mmc_spi_read_engine.sv
// MMC/SD SPI-mode bulk read engine: clocks 0xFF dummy bytes, shifts MISO in MSB first,
// packs bytes into N-bit words and pushes them into a write-side FIFO with backpressure.
module mmc_spi_read_engine #(
  parameter int N     = 16,
  parameter int DIV_W = 8,
  parameter int LEN_W = 16
) (
  input  logic             iWR_CLOCK,
  input  logic             inRESET,
  input  logic             iRESET_SYNC,
  input  logic             iSTART,
  input  logic [LEN_W-1:0] iLENGTH,
  input  logic [DIV_W-1:0] iCLK_DIV,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oSPI_CLK,
  output logic             oSPI_MOSI,
  input  logic             iSPI_MISO,
  output logic             oFIFO_WR_EN,
  output logic [N-1:0]     oFIFO_WR_DATA,
  input  logic             iFIFO_FULL
);
  localparam int BYTES = N / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, PUSH, DONE} state_t;

  state_t           r_state, w_next;
  logic [LEN_W-1:0] r_len;
  logic [DIV_W-1:0] r_div, r_divcnt;
  logic             r_sclk;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_shift;
  logic [N-1:0]     r_word;
  logic [BI_W-1:0]  r_bidx;

  logic w_tick, w_rise, w_fall, w_byte_done, w_word_full, w_last, w_wr_en;

  // A tick is the end of one SPI half-period; its direction follows the current clock level.
  assign w_tick      = (r_state == SHIFT) && (r_divcnt == '0);
  assign w_rise      = w_tick && !r_sclk;
  assign w_fall      = w_tick && r_sclk;
  assign w_byte_done = w_fall && (r_bitcnt == 3'd7);
  assign w_word_full = (r_bidx == BI_W'(BYTES - 1));
  assign w_last      = (r_len == LEN_W'(1));
  assign w_wr_en     = (r_state == PUSH) && !iFIFO_FULL && !iRESET_SYNC;

  assign oBUSY         = (r_state == SHIFT) || (r_state == PUSH);
  assign oDONE         = (r_state == DONE) && !iRESET_SYNC;
  assign oSPI_CLK      = r_sclk;
  assign oSPI_MOSI     = 1'b1;
  assign oFIFO_WR_EN   = w_wr_en;
  assign oFIFO_WR_DATA = w_wr_en ? r_word : '0;

  always_ff @(posedge iWR_CLOCK or negedge inRESET) begin
    if (!inRESET) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (iRESET_SYNC) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (iSTART) w_next = (iLENGTH == '0) ? DONE : SHIFT;
        SHIFT:   if (w_byte_done && (w_last || w_word_full)) w_next = PUSH;
        PUSH:    if (!iFIFO_FULL) w_next = (r_len == '0) ? DONE : SHIFT;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge iWR_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_len    <= '0;
      r_div    <= '0;
      r_divcnt <= '0;
      r_sclk   <= 1'b0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_word   <= '0;
      r_bidx   <= '0;
    end else if (iRESET_SYNC) begin
      // abort drops any partially assembled word along with the rest of the state
      r_len    <= '0;
      r_div    <= '0;
      r_divcnt <= '0;
      r_sclk   <= 1'b0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_word   <= '0;
      r_bidx   <= '0;
    end else begin
      case (r_state)
        IDLE: if (iSTART) begin
          r_len    <= iLENGTH;
          r_div    <= iCLK_DIV;
          r_divcnt <= iCLK_DIV;
          r_sclk   <= 1'b0;
          r_bitcnt <= '0;
          r_word   <= '0;
          r_bidx   <= '0;
        end
        SHIFT: begin
          if (w_tick) begin
            r_sclk   <= ~r_sclk;
            r_divcnt <= r_div;
            if (w_rise) r_shift <= {r_shift[6:0], iSPI_MISO};
            if (w_fall) r_bitcnt <= r_bitcnt + 3'd1;
            if (w_byte_done) begin
              // first byte of a word lands in the top lane, later bytes descend
              for (int b = 0; b < BYTES; b++)
                if (r_bidx == BI_W'(b)) r_word[N-1-8*b -: 8] <= r_shift;
              r_len <= r_len - 1'b1;
              if (!w_word_full) r_bidx <= r_bidx + 1'b1;
            end
          end else begin
            r_divcnt <= r_divcnt - 1'b1;
          end
        end
        PUSH: begin
          r_sclk   <= 1'b0;
          r_divcnt <= r_div;
          if (!iFIFO_FULL) begin
            r_word <= '0;
            r_bidx <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mmc_spi_read_engine.sv
// Directed bench for mmc_spi_read_engine: an SPI card model serves bytes MSB first,
// each scenario task measures one transfer and compares against hand-computed values.
module tb_mmc_spi_read_engine;
  localparam int N = 16, DIV_W = 8, LEN_W = 16;

  logic             clk = 1'b0, rst_n = 1'b0, rsync = 1'b0, start = 1'b0, full = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [DIV_W-1:0] div = '0;
  logic             busy, done, sclk, mosi, miso, wr_en;
  logic [N-1:0]     wr_data;

  int nvec = 0, nmis = 0;

  // card model: bit index advances on every SCLK rising edge since the load point
  int          rcnt = 0, tx_base = 0;
  logic [63:0] tx_data = '1;
  always #5 clk = ~clk;
  always @(posedge sclk) rcnt++;
  assign miso = tx_data[63 - ((rcnt - tx_base) % 64)];

  mmc_spi_read_engine #(.N(N), .DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .iWR_CLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rsync), .iSTART(start),
    .iLENGTH(len), .iCLK_DIV(div), .oBUSY(busy), .oDONE(done), .oSPI_CLK(sclk),
    .oSPI_MOSI(mosi), .iSPI_MISO(miso), .oFIFO_WR_EN(wr_en), .oFIFO_WR_DATA(wr_data),
    .iFIFO_FULL(full));

  int         m_rises, m_nwr, m_hmin, m_hmax, m_rmin, m_ndone, m_done_cyc, m_wr_cyc;
  int         m_wr0_cyc, m_drop_cyc, m_bad, m_stall_bad, m_timeout;
  logic       m_abort_busy, m_abort_sclk;
  logic [N-1:0] m_wr [0:7];

  task automatic xfer(input int l, input int d, input logic [63:0] data, input int stall,
                      input int abort_rise, input int restart_at, input int budget);
    int cyc, hrun, last_rise, stall_cnt, abort_cnt, tail;
    logic prev;
    tx_data = data; tx_base = rcnt;
    m_rises = 0; m_nwr = 0; m_hmin = 9999; m_hmax = 0; m_rmin = 9999; m_ndone = 0;
    m_done_cyc = -1; m_wr_cyc = -1; m_wr0_cyc = -1; m_drop_cyc = -1; m_bad = 0;
    m_stall_bad = 0; m_timeout = 0; m_abort_busy = 1'b1; m_abort_sclk = 1'b1;
    for (int i = 0; i < 8; i++) m_wr[i] = '0;
    cyc = 0; hrun = 0; last_rise = 0; stall_cnt = 0; abort_cnt = 0; tail = 0; prev = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; len = LEN_W'(l); div = DIV_W'(d); full = (stall > 0);
    forever begin
      @(negedge clk); cyc++;
      if (sclk && !prev) begin
        m_rises++;
        if (last_rise > 0 && cyc - last_rise < m_rmin) m_rmin = cyc - last_rise;
        last_rise = cyc;
      end
      if (sclk) hrun++;
      else if (hrun > 0) begin
        if (hrun < m_hmin) m_hmin = hrun;
        if (hrun > m_hmax) m_hmax = hrun;
        hrun = 0;
      end
      prev = sclk;
      if (wr_en) begin
        if (m_nwr < 8) m_wr[m_nwr] = wr_data;
        if (m_nwr == 0) m_wr0_cyc = cyc;
        m_wr_cyc = cyc;
        m_nwr++;
      end
      if (wr_en && full) m_bad++;
      if (!wr_en && wr_data != '0) m_bad++;
      if (sclk && !busy) m_bad++;
      if (done && busy) m_bad++;
      if (!mosi) m_bad++;
      if (done) begin m_ndone++; m_done_cyc = cyc; end
      if (stall > 0 && stall_cnt == 0 && m_rises == 16 && !sclk) stall_cnt = 1;
      if (stall_cnt >= 1 && stall_cnt <= stall) begin
        if (sclk || wr_en) m_stall_bad++;
        stall_cnt++;
      end
      if (abort_cnt == 2) begin m_abort_busy = busy; m_abort_sclk = sclk; abort_cnt = 3; end
      if (abort_cnt == 3) begin tail++; if (tail > 12) break; end
      if (done) break;
      if (cyc > budget) begin m_timeout = 1; break; end
      @(posedge clk); #1;
      start = (restart_at > 0 && cyc + 1 == restart_at);
      if (start) len = LEN_W'(5);
      if (stall_cnt == stall + 1 && full) begin full = 1'b0; m_drop_cyc = cyc + 1; end
      if (abort_cnt == 1) begin rsync = 1'b0; abort_cnt = 2; end
      if (abort_rise > 0 && abort_cnt == 0 && m_rises == abort_rise) begin
        rsync = 1'b1; abort_cnt = 1;
      end
    end
    @(posedge clk); #1; start = 1'b0; full = 1'b0; rsync = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1; len = 16'd3; full = 1'b0;
    @(negedge clk);
    nvec++; if (busy !== 1'b0)  begin nmis++; $display("FAIL reset_busy: got %b want 0", busy); end
    nvec++; if (done !== 1'b0)  begin nmis++; $display("FAIL reset_done: got %b want 0", done); end
    nvec++; if (sclk !== 1'b0)  begin nmis++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    nvec++; if (mosi !== 1'b1)  begin nmis++; $display("FAIL reset_mosi: got %b want 1", mosi); end
    nvec++; if (wr_en !== 1'b0) begin nmis++; $display("FAIL reset_wren: got %b want 0", wr_en); end
    nvec++; if (wr_data !== '0) begin nmis++; $display("FAIL reset_wdata: got %h want 0", wr_data); end
    @(posedge clk); #1; start = 1'b0; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_basic();
    xfer(2, 0, {8'hA5, 8'h3C, 48'hFFFF_FFFF_FFFF}, 0, 0, 0, 200);
    nvec++; if (m_timeout !== 0) begin nmis++; $display("FAIL basic_timeout: got %0d want 0", m_timeout); end
    nvec++; if (m_nwr !== 1) begin nmis++; $display("FAIL basic_nwr: got %0d want 1", m_nwr); end
    nvec++; if (m_wr[0] !== 16'hA53C) begin nmis++; $display("FAIL basic_word: got %h want a53c", m_wr[0]); end
    nvec++; if (m_done_cyc - m_wr_cyc !== 1) begin nmis++; $display("FAIL basic_done_lat: got %0d want 1", m_done_cyc - m_wr_cyc); end
    nvec++; if (m_rises !== 16) begin nmis++; $display("FAIL basic_rises: got %0d want 16", m_rises); end
    nvec++; if (m_hmin !== 1 || m_hmax !== 1) begin nmis++; $display("FAIL basic_high: got %0d..%0d want 1", m_hmin, m_hmax); end
    nvec++; if (m_rmin !== 2) begin nmis++; $display("FAIL basic_period: got %0d want 2", m_rmin); end
    nvec++; if (m_ndone !== 1) begin nmis++; $display("FAIL basic_ndone: got %0d want 1", m_ndone); end
    nvec++; if (m_bad !== 0) begin nmis++; $display("FAIL basic_invariant: got %0d want 0", m_bad); end
  endtask

  task automatic test_div3();
    xfer(3, 3, {8'h11, 8'h22, 8'h33, 40'hFF_FFFF_FFFF}, 0, 0, 0, 600);
    nvec++; if (m_nwr !== 2) begin nmis++; $display("FAIL div3_nwr: got %0d want 2", m_nwr); end
    nvec++; if (m_wr[0] !== 16'h1122) begin nmis++; $display("FAIL div3_word0: got %h want 1122", m_wr[0]); end
    nvec++; if (m_wr[1] !== 16'h3300) begin nmis++; $display("FAIL div3_word1: got %h want 3300", m_wr[1]); end
    nvec++; if (m_hmin !== 4 || m_hmax !== 4) begin nmis++; $display("FAIL div3_high: got %0d..%0d want 4", m_hmin, m_hmax); end
    nvec++; if (m_rmin !== 8) begin nmis++; $display("FAIL div3_period: got %0d want 8", m_rmin); end
    nvec++; if (m_rises !== 24) begin nmis++; $display("FAIL div3_rises: got %0d want 24", m_rises); end
    nvec++; if (m_bad !== 0) begin nmis++; $display("FAIL div3_invariant: got %0d want 0", m_bad); end
  endtask

  task automatic test_zero_len();
    xfer(0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 20);
    nvec++; if (m_done_cyc !== 2) begin nmis++; $display("FAIL zero_done_cyc: got %0d want 2", m_done_cyc); end
    nvec++; if (m_rises !== 0) begin nmis++; $display("FAIL zero_rises: got %0d want 0", m_rises); end
    nvec++; if (m_nwr !== 0) begin nmis++; $display("FAIL zero_nwr: got %0d want 0", m_nwr); end
  endtask

  task automatic test_stall();
    xfer(4, 0, {32'h0102_0304, 32'hFFFF_FFFF}, 20, 0, 0, 300);
    nvec++; if (m_stall_bad !== 0) begin nmis++; $display("FAIL stall_quiet: got %0d want 0", m_stall_bad); end
    nvec++; if (m_drop_cyc <= 0 || m_wr0_cyc !== m_drop_cyc) begin nmis++; $display("FAIL stall_wr_cyc: got %0d want %0d", m_wr0_cyc, m_drop_cyc); end
    nvec++; if (m_nwr !== 2) begin nmis++; $display("FAIL stall_nwr: got %0d want 2", m_nwr); end
    nvec++; if (m_wr[0] !== 16'h0102) begin nmis++; $display("FAIL stall_word0: got %h want 0102", m_wr[0]); end
    nvec++; if (m_wr[1] !== 16'h0304) begin nmis++; $display("FAIL stall_word1: got %h want 0304", m_wr[1]); end
    nvec++; if (m_bad !== 0) begin nmis++; $display("FAIL stall_invariant: got %0d want 0", m_bad); end
  endtask

  task automatic test_sync_reset();
    xfer(2, 1, {16'hF00F, 48'hFFFF_FFFF_FFFF}, 0, 3, 0, 200);
    nvec++; if (m_abort_busy !== 1'b0) begin nmis++; $display("FAIL abort_busy: got %b want 0", m_abort_busy); end
    nvec++; if (m_abort_sclk !== 1'b0) begin nmis++; $display("FAIL abort_sclk: got %b want 0", m_abort_sclk); end
    nvec++; if (m_nwr !== 0) begin nmis++; $display("FAIL abort_nwr: got %0d want 0", m_nwr); end
    nvec++; if (m_ndone !== 0) begin nmis++; $display("FAIL abort_ndone: got %0d want 0", m_ndone); end
    xfer(2, 1, {16'h5AC3, 48'hFFFF_FFFF_FFFF}, 0, 0, 0, 200);
    nvec++; if (m_nwr !== 1 || m_wr[0] !== 16'h5AC3) begin nmis++; $display("FAIL abort_after_word: got %0d x %h want 1 x 5ac3", m_nwr, m_wr[0]); end
    nvec++; if (m_ndone !== 1) begin nmis++; $display("FAIL abort_after_done: got %0d want 1", m_ndone); end
  endtask

  task automatic test_start_ignored();
    xfer(2, 0, {16'h1234, 48'hFFFF_FFFF_FFFF}, 0, 0, 5, 200);
    nvec++; if (m_nwr !== 1) begin nmis++; $display("FAIL restart_nwr: got %0d want 1", m_nwr); end
    nvec++; if (m_wr[0] !== 16'h1234) begin nmis++; $display("FAIL restart_word: got %h want 1234", m_wr[0]); end
    nvec++; if (m_rises !== 16) begin nmis++; $display("FAIL restart_rises: got %0d want 16", m_rises); end
    nvec++; if (m_ndone !== 1) begin nmis++; $display("FAIL restart_ndone: got %0d want 1", m_ndone); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div3();
    test_zero_len();
    test_stall();
    test_sync_reset();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
